// File: rtl/pin_input_debouncer.sv
// Pin-bus front end: 2-flop synchroniser, independent per-bit debounce, and a small
// first-word-fall-through FIFO that reports each debounced change as {new level, flipped bits}.
module pin_input_debouncer #(
    parameter int               WIDTH         = 8,
    parameter int               STABLE_CYCLES = 4,
    parameter int               FIFO_DEPTH    = 4,
    parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [WIDTH-1:0]            pin_in,
    output logic [WIDTH-1:0]            level_out,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [WIDTH-1:0]            out_value,
    output logic [WIDTH-1:0]            out_mask,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        overflow,
    input  logic                        clear_overflow
);

    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [7:0]       CNT_LAST   = 8'(STABLE_CYCLES - 1);
    localparam logic [PTR_W:0]   LEVEL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   LEVEL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] level_d;
    logic [WIDTH-1:0] flip_mask;
    logic [7:0]       cnt_q [WIDTH];
    logic [7:0]       cnt_d [WIDTH];

    logic [WIDTH-1:0] mem_value_q [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_value_d [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_mask_q  [FIFO_DEPTH];
    logic [WIDTH-1:0] mem_mask_d  [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] rd_ptr_d;
    logic [PTR_W:0]   count_q;
    logic [PTR_W:0]   count_d;
    logic             overflow_q;
    logic             overflow_d;

    logic fifo_full;
    logic push_req;
    logic push_ok;
    logic pop;
    logic drop;

    // A bit only flips once it has disagreed with the debounced level for
    // STABLE_CYCLES consecutive synchronised samples; any agreement restarts it.
    always_comb begin
        level_d   = level_q;
        flip_mask = '0;
        cnt_d     = cnt_q;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = 8'd0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i]   = sync2_q[i];
                cnt_d[i]     = 8'd0;
                flip_mask[i] = 1'b1;
            end else begin
                cnt_d[i] = cnt_q[i] + 8'd1;
            end
        end
    end

    // A push into a full FIFO still succeeds if the head leaves on the same edge.
    always_comb begin
        fifo_full = (count_q == LEVEL_FULL);
        push_req  = |flip_mask;
        pop       = out_valid && out_ready;
        push_ok   = push_req && (!fifo_full || pop);
        drop      = push_req && fifo_full && !pop;

        mem_value_d = mem_value_q;
        mem_mask_d  = mem_mask_q;
        if (push_ok) begin
            mem_value_d[wr_ptr_q] = level_d;
            mem_mask_d[wr_ptr_q]  = flip_mask;
        end

        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;

        case ({push_ok, pop})
            2'b10:   count_d = count_q + LEVEL_ONE;
            2'b01:   count_d = count_q - LEVEL_ONE;
            default: count_d = count_q;
        endcase

        if (drop) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // The synchroniser is a bare flop chain so both stages can be placed together.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q     <= RESET_VALUE;
            sync2_q     <= RESET_VALUE;
            level_q     <= RESET_VALUE;
            cnt_q       <= '{default: '0};
            mem_value_q <= '{default: '0};
            mem_mask_q  <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= pin_in;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            cnt_q       <= cnt_d;
            mem_value_q <= mem_value_d;
            mem_mask_q  <= mem_mask_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
        end
    end

    assign level_out  = level_q;
    assign out_valid  = (count_q != '0);
    assign out_value  = out_valid ? mem_value_q[rd_ptr_q] : '0;
    assign out_mask   = out_valid ? mem_mask_q[rd_ptr_q] : '0;
    assign fifo_level = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pin_input_debouncer.sv
// Bench for pin_input_debouncer: directed scenarios plus random pin traffic, checked by a
// window-based reference model feeding an event scoreboard and a per-cycle monitor.
module tb_pin_input_debouncer;

    localparam int         WIDTH  = 8;
    localparam int         STABLE = 4;
    localparam int         DEPTH  = 4;
    localparam logic [7:0] RV     = 8'h00;

    logic       clock          = 1'b0;
    logic       reset          = 1'b1;
    logic [7:0] pin_in         = 8'h00;
    logic       out_ready      = 1'b0;
    logic       clear_overflow = 1'b0;
    logic [7:0] level_out;
    logic [7:0] out_value;
    logic [7:0] out_mask;
    logic       out_valid;
    logic       overflow;
    logic [2:0] fifo_level;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pin_input_debouncer #(
        .WIDTH(WIDTH), .STABLE_CYCLES(STABLE), .FIFO_DEPTH(DEPTH), .RESET_VALUE(RV)
    ) dut (
        .clock(clock), .reset(reset), .pin_in(pin_in), .level_out(level_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
        .out_mask(out_mask), .fifo_level(fifo_level), .overflow(overflow),
        .clear_overflow(clear_overflow)
    );

    // Reference model: a bit flips when the last STABLE samples seen after the
    // two-stage delay all disagree with the current level.
    logic [7:0]  pipe [2];
    logic [7:0]  hist [$];
    logic [7:0]  m_level;
    logic [15:0] exp_q [$];
    int          m_occ = 0;
    logic        m_ovf;
    logic        m_pop;
    logic        m_drop;
    logic        m_all;
    logic [7:0]  m_flip;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            pipe[0] = RV;
            pipe[1] = RV;
            hist.delete();
            m_level = RV;
            exp_q.delete();
            m_occ = 0;
            m_ovf = 1'b0;
        end else begin
            m_pop = (m_occ > 0) && out_ready;
            hist.push_back(pipe[0]);
            if (hist.size() > STABLE) void'(hist.pop_front());
            pipe[0] = pipe[1];
            pipe[1] = pin_in;
            m_flip = 8'h00;
            if (hist.size() == STABLE) begin
                for (int b = 0; b < WIDTH; b++) begin
                    m_all = 1'b1;
                    foreach (hist[k]) if (hist[k][b] == m_level[b]) m_all = 1'b0;
                    m_flip[b] = m_all;
                end
            end
            m_level = m_level ^ m_flip;
            m_drop = (m_flip != 8'h00) && !(m_occ < DEPTH || m_pop);
            if (m_flip != 8'h00 && !m_drop) begin
                exp_q.push_back({m_level, m_flip});
                m_occ++;
            end
            if (m_drop) m_ovf = 1'b1;
            else if (clear_overflow) m_ovf = 1'b0;
            if (m_pop) m_occ--;
        end
    end

    // Monitor: compares visible state every cycle and retires scoreboard entries on handshakes.
    always @(negedge clock) begin
        cmp("level_out", 32'(level_out), 32'(m_level));
        cmp("out_valid", 32'(out_valid), 32'(m_occ > 0));
        cmp("fifo_level", 32'(fifo_level), 32'(m_occ));
        cmp("overflow", 32'(overflow), 32'(m_ovf));
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL event: got {%0h,%0h}, want no event at %0t", out_value, out_mask, $time);
            end else begin
                cmp("out_value", 32'(out_value), 32'(exp_q[0][15:8]));
                cmp("out_mask", 32'(out_mask), 32'(exp_q[0][7:0]));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] p, input logic r, input logic c, input int n);
        pin_in         = p;
        out_ready      = r;
        clear_overflow = c;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic checkOutput(input string name, input logic [7:0] lvl, input logic vld,
                               input logic [2:0] fl, input logic [7:0] val,
                               input logic [7:0] msk, input logic ovf);
        cmp({name, ".level"}, 32'(level_out), 32'(lvl));
        cmp({name, ".valid"}, 32'(out_valid), 32'(vld));
        cmp({name, ".fifo_level"}, 32'(fifo_level), 32'(fl));
        cmp({name, ".value"}, 32'(out_value), 32'(val));
        cmp({name, ".mask"}, 32'(out_mask), 32'(msk));
        cmp({name, ".overflow"}, 32'(overflow), 32'(ovf));
    endtask

    logic [7:0] rnd_pin;
    logic [31:0] rnd;

    initial begin
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        checkOutput("reset", 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

        applyStimulus(8'h01, 1'b1, 1'b0, 5);
        checkOutput("step_edge4", 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b0, 1);
        checkOutput("step_edge5", 8'h01, 1'b1, 3'd1, 8'h01, 8'h01, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b0, 2);

        applyStimulus(8'h05, 1'b1, 1'b0, 3);
        applyStimulus(8'h01, 1'b1, 1'b0, 8);
        checkOutput("glitch", 8'h01, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

        applyStimulus(8'h00, 1'b1, 1'b0, 8);
        applyStimulus(8'hA5, 1'b1, 1'b0, 6);
        checkOutput("multi_bit", 8'hA5, 1'b1, 3'd1, 8'hA5, 8'hA5, 1'b0);
        applyStimulus(8'hA5, 1'b1, 1'b0, 2);
        applyStimulus(8'hA4, 1'b1, 1'b0, 6);
        checkOutput("single_bit", 8'hA4, 1'b1, 3'd1, 8'hA4, 8'h01, 1'b0);
        applyStimulus(8'hA4, 1'b1, 1'b0, 2);

        applyStimulus(8'h10, 1'b0, 1'b0, 7);
        applyStimulus(8'h20, 1'b0, 1'b0, 7);
        applyStimulus(8'h30, 1'b0, 1'b0, 7);
        applyStimulus(8'h40, 1'b0, 1'b0, 7);
        applyStimulus(8'h50, 1'b0, 1'b0, 7);
        checkOutput("overflow", 8'h50, 1'b1, 3'd4, 8'h10, 8'hB4, 1'b1);
        applyStimulus(8'h50, 1'b1, 1'b0, 4);
        checkOutput("ovf_drain", 8'h50, 1'b0, 3'd0, 8'h00, 8'h00, 1'b1);
        applyStimulus(8'h50, 1'b0, 1'b1, 1);
        checkOutput("ovf_clear", 8'h50, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);

        applyStimulus(8'h11, 1'b0, 1'b0, 7);
        applyStimulus(8'h22, 1'b0, 1'b0, 7);
        applyStimulus(8'h33, 1'b0, 1'b0, 7);
        applyStimulus(8'h44, 1'b0, 1'b0, 7);
        checkOutput("full", 8'h44, 1'b1, 3'd4, 8'h11, 8'h41, 1'b0);
        applyStimulus(8'h55, 1'b0, 1'b0, 5);
        applyStimulus(8'h55, 1'b1, 1'b0, 1);
        checkOutput("full_push_pop", 8'h55, 1'b1, 3'd4, 8'h22, 8'h33, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b0, 3);
        checkOutput("last_event", 8'h55, 1'b1, 3'd1, 8'h55, 8'h11, 1'b0);
        applyStimulus(8'h55, 1'b1, 1'b0, 1);

        applyStimulus(8'h01, 1'b0, 1'b0, 7);
        applyStimulus(8'h02, 1'b0, 1'b0, 7);
        applyStimulus(8'h03, 1'b0, 1'b0, 7);
        checkOutput("three_queued", 8'h03, 1'b1, 3'd3, 8'h01, 8'h54, 1'b0);
        applyStimulus(8'h0F, 1'b0, 1'b0, 4);
        reset = 1'b1;
        #1;
        checkOutput("mid_reset", 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        applyStimulus(8'h0F, 1'b0, 1'b0, 5);
        checkOutput("post_reset_edge4", 8'h00, 1'b0, 3'd0, 8'h00, 8'h00, 1'b0);
        applyStimulus(8'h0F, 1'b0, 1'b0, 1);
        checkOutput("post_reset_edge5", 8'h0F, 1'b1, 3'd1, 8'h0F, 8'h0F, 1'b0);

        rnd_pin = 8'h0F;
        for (int it = 0; it < 250; it++) begin
            rnd = $urandom;
            if (rnd[3:0] < 4'd6) rnd_pin = rnd_pin ^ (8'h01 << rnd[6:4]);
            else rnd_pin = 8'($urandom);
            if (it == 120) begin
                reset = 1'b1;
                @(posedge clock);
                #1;
                reset = 1'b0;
            end
            applyStimulus(rnd_pin, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                          $urandom_range(1, 8));
        end

        applyStimulus(rnd_pin, 1'b1, 1'b0, 20);
        cmp("drain_queue", 32'(exp_q.size()), 32'd0);
        cmp("drain_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pin_input_debouncer.md
Name: pin_input_debouncer

Overview:
- Consumer stage directly downstream of the iCE40 SB_IO input path.
- Takes the raw 8-bit D_IN_0 pin bus, synchronises it into the clock domain, and debounces each bit independently.
- Emits per-change events (new value plus changed-bit mask) through a small first-word-fall-through FIFO with a valid/ready handshake.
- Also presents the current debounced level continuously.

Parameters:
- WIDTH, 8, pin bus width.
- STABLE_CYCLES, 4, consecutive synchronised samples a bit must differ from its debounced value before that value flips; legal range 1..255.
- FIFO_DEPTH, 4, event FIFO entries; power of two, at least 2.
- RESET_VALUE, 0 (WIDTH bits), reset value of the synchroniser flops and the debounced level.

Ports:
- clock  input  1  single clock; all state on its rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- pin_in  input  WIDTH  raw pin data from SB_IO D_IN_0; asynchronous to clock.
- level_out  output  WIDTH  current debounced level.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts the head event when high together with out_valid.
- out_value  output  WIDTH  debounced level captured at the event (head entry).
- out_mask  output  WIDTH  bits that flipped at the event (head entry); never zero while out_valid.
- fifo_level  output  clog2(FIFO_DEPTH)+1  number of queued events.
- overflow  output  1  sticky; set when an event is dropped.
- clear_overflow  input  1  synchronous clear of overflow.

Behaviour:
- Reset (asynchronous assert, synchronous-domain release):
  - sync1, sync2 and level_out = RESET_VALUE.
  - All per-bit counters = 0.
  - FIFO empty: out_valid = 0, fifo_level = 0.
  - out_value = out_mask = 0 while empty.
  - overflow = 0.
- Synchroniser: pin_in -> sync1 -> sync2, plain 2-flop chain per bit; no logic between the flops.
- Per-bit debounce (counter width 8):
  - If sync2[i] == level_out[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CYCLES-1: level_out[i] <= sync2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - A glitch shorter than STABLE_CYCLES samples never reaches level_out, and its counter restarts from 0.
- Latency: a steady pin change is first captured at edge 0. level_out updates at edge STABLE_CYCLES+1 (edge 5 at default) and is visible after that edge.
- Event generation:
  - flip_mask = bits whose level_out updates on this edge.
  - If flip_mask != 0, push {new level, flip_mask} on that same edge.
  - out_valid rises after that edge, i.e. the same cycle level_out changes.
  - Several bits flipping on one edge produce one event with a multi-bit mask.
- FIFO:
  - First-word-fall-through; out_value and out_mask are driven from the head entry, which stays stable while out_valid && !out_ready.
  - Pop on out_valid && out_ready.
  - Push while full with no pop: event dropped, overflow <= 1, FIFO contents unchanged.
  - Push while full with a simultaneous pop: both happen, no drop, fifo_level unchanged.
  - Push while empty: no bypass to the consumer; out_valid asserts the following cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level = pushes - pops, in range 0..FIFO_DEPTH.
- overflow: if clear_overflow and a drop occur on the same edge, the drop wins and overflow stays 1.
- Reset mid-operation: all queued events discarded and counters zeroed. On release, level_out = RESET_VALUE; if pins differ, they debounce afresh and generate events normally.

Test Plan:
- Reset, pin_in=0x00, then pin_in steps to 0x01 at edge 0 and holds -> level_out=0x01 after edge 5; one event {0x01, 0x01}; fifo_level=1.
- pin_in bit 2 pulses high for 3 cycles only -> level_out unchanged, no event, out_valid stays 0.
- pin_in steps 0x00->0xA5 in one cycle -> single event {0xA5, 0xA5}. Then 0xA5->0xA4 -> event {0xA4, 0x01}.
- out_ready=0; generate 5 distinct settled changes -> fifo_level=4 and overflow=1 after the 5th; the first 4 events pop in order with correct values; clear_overflow -> overflow=0.
- FIFO full with a new event arriving on the same edge as a pop (out_ready=1) -> no overflow, fifo_level stays 4, the new event is read last.
- Assert reset while 3 events are queued and a bit counter is at 2 -> out_valid=0 and level_out=RESET_VALUE immediately. After release with pins held at 0x0F -> event {0x0F, 0x0F} after STABLE_CYCLES+2 edges.
